ram_arb_256x11: RTL and testbench
=================================

RAM_ARB_256X11 -- requirements
Module: ram_arb_256x11

Interface
REQ-001 SHALL have parameter WIDTH, default 256, data word width.
REQ-002 SHALL have parameter DEPTH, default 11, number of memory words.
REQ-003 SHALL have parameter AW, default 4, address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports reqA, reqB  input  1 each  access request per requester.
REQ-007 SHALL have ports weA, weB  input  1 each  1 = write, 0 = read.
REQ-008 SHALL have ports addrA, addrB  input  AW each  word address.
REQ-009 SHALL have ports dinA, dinB  input  WIDTH each  write data.
REQ-010 SHALL have ports gntA, gntB  output  1 each  combinational grant, same cycle as request.
REQ-011 SHALL have ports doutA, doutB  output  WIDTH each  registered read data.
REQ-012 SHALL have ports rvalidA, rvalidB  output  1 each  one-cycle pulse, dout valid.
REQ-013 SHALL have port errA, errB  output  1 each  sticky out-of-range address flag.

Function
REQ-014 SHALL contain one DEPTH x WIDTH memory, with at most one access per clk cycle.
REQ-015 Grant SHALL be combinational: gntX = reqX and the arbiter selects X; gntA and gntB are never both 1.
REQ-016 Single request SHALL be granted immediately, with no idle cycle.
REQ-017 Both requests in the same cycle: grant SHALL go to the requester not granted most recently (round-robin pointer).
REQ-018 Pointer SHALL update only on an edge where a grant occurs, recording the granted side; it is unchanged on idle cycles.
REQ-019 The access SHALL commit at the rising edge where reqX&gntX=1; a requester holds req/we/addr/din stable until granted.
REQ-020 Granted write (weX=1, addrX<DEPTH): memory[addrX] <= dinX at that edge.
REQ-021 Granted read (weX=0, addrX<DEPTH): doutX <= memory[addrX] and rvalidX=1 for exactly the following cycle (latency 1).
REQ-022 doutX SHALL hold its last value until the next granted read by X.
REQ-023 Read after write to the same address SHALL return the new data, including a write granted in cycle n followed by a read granted in cycle n+1.
REQ-024 Out-of-range address (addrX >= DEPTH, i.e. 11..15) SHALL be handled as follows:
  - a write is discarded (memory unchanged);
  - a read returns doutX=0 with rvalidX=1;
  - errX is set and stays set until reset.
REQ-025 Requests pending back-to-back from both sides SHALL strictly alternate A,B,A,B; each side's worst-case wait is 1 cycle.
REQ-026 A single requester holding reqX continuously SHALL be granted every cycle (full throughput).
REQ-027 The write side has no priority over reads; only the round-robin rule applies.

Reset
REQ-028 On rst=1 the block SHALL immediately (asynchronously) reset its state:
  - rvalidA/B = 0, doutA/B = 0, errA/B = 0;
  - pointer = "B last", so A wins the first contention.
REQ-029 During rst=1, gntA/gntB SHALL be 0 and no memory write SHALL occur.
REQ-030 Memory contents SHALL NOT be reset; they are undefined until written.
REQ-031 Reset asserted during the latency cycle of a read SHALL suppress that rvalid pulse.
REQ-032 The first grant after rst deasserts SHALL be possible on the first rising edge with rst=0.

Verification
REQ-033 Write then read: A writes addr 3 = 256'hA5..A5, next cycle A reads addr 3 -> the cycle after, rvalidA=1 and doutA=256'hA5..A5.
REQ-034 Contention after reset: reqA=reqB=1 reads of addr 0 and 1, held 4 cycles:
  - grants go A,B,A,B;
  - rvalidA and rvalidB pulse on alternate cycles with correct data.
REQ-035 Cross-port write/read: B writes addr 10 = 1 while A reads addr 10 in the same cycle, both asserted after a B grant:
  - A is granted first and returns old data;
  - B's write commits next;
  - a subsequent A read returns 1.
REQ-036 Out of range: A writes addr 12, then A reads addr 12 -> memory unchanged, doutA=0, rvalidA=1, errA=1 stays set; errB=0.
REQ-037 Reset mid-read: A read granted, rst pulses before the next edge -> rvalidA stays 0, doutA=0, errA=0; memory data written before reset remains readable afterwards.
REQ-038 Idle and streaming: no requests for 5 cycles -> no grants, no rvalid, pointer unchanged; then B alone for 8 cycles -> gntB=1 every cycle.

Source files
------------

// File: rtl/ram_arb_256x11.sv
// ram_arb_256x11: two requesters share one single-port DEPTH x WIDTH memory.
// A combinational round-robin arbiter grants one requester per cycle. The
// granted access commits on the same rising edge. Reads return registered
// data one cycle later, together with a one-cycle rvalid pulse.
// Out-of-range addresses never touch the memory. They set a sticky error
// flag for the requester that issued them.
module ram_arb_256x11 #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 11,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqA,
  input  logic             reqB,
  input  logic             weA,
  input  logic             weB,
  input  logic [AW-1:0]    addrA,
  input  logic [AW-1:0]    addrB,
  input  logic [WIDTH-1:0] dinA,
  input  logic [WIDTH-1:0] dinB,
  output logic             gntA,
  output logic             gntB,
  output logic [WIDTH-1:0] doutA,
  output logic [WIDTH-1:0] doutB,
  output logic             rvalidA,
  output logic             rvalidB,
  output logic             errA,
  output logic             errB
);

  // One extra bit, so the limit still fits when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Round-robin pointer: 1 = B was granted most recently, so A wins the next tie.
  logic             last_b;

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_din;
  logic             sel_in_range;
  logic             any_gnt;

  // Arbitration: a lone request wins at once, a tie goes to the side not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    gntA = 1'b0;
    gntB = 1'b0;
    if (!rst) begin
      gntA = reqA && (!reqB || last_b);
      gntB = reqB && (!reqA || !last_b);
    end
  end

  // Mux the winning requester's command onto the shared memory port.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    if (gntA) begin
      sel_we   = weA;
      sel_addr = addrA;
      sel_din  = dinA;
    end else if (gntB) begin
      sel_we   = weB;
      sel_addr = addrB;
      sel_din  = dinB;
    end
    sel_in_range = {1'b0, sel_addr} < DEPTH_LIM;
    any_gnt      = gntA || gntB;
  end

  // Memory write port; an out-of-range write is dropped.
  // NOTE: the storage array has no reset; its contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (any_gnt && sel_we && sel_in_range) begin
      mem[sel_addr] <= sel_din;
    end
  end

  // Pointer, registered read data, read-valid pulses and sticky error flags.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b  <= 1'b1;
      doutA   <= '0;
      doutB   <= '0;
      rvalidA <= 1'b0;
      rvalidB <= 1'b0;
      errA    <= 1'b0;
      errB    <= 1'b0;
    end else begin
      rvalidA <= gntA && !weA;
      rvalidB <= gntB && !weB;
      if (any_gnt) begin
        last_b <= gntB;
      end
      if (gntA && !weA) begin
        doutA <= sel_in_range ? mem[sel_addr] : '0;
      end
      if (gntB && !weB) begin
        doutB <= sel_in_range ? mem[sel_addr] : '0;
      end
      if (gntA && !sel_in_range) begin
        errA <= 1'b1;
      end
      if (gntB && !sel_in_range) begin
        errB <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arb_256x11.sv
// tb_ram_arb_256x11: directed-vector bench for ram_arb_256x11.
// Inputs change and outputs are sampled on the falling clock edge.
// Grants are sampled 1 ns after the inputs settle.
module tb_ram_arb_256x11;

  localparam int WIDTH = 256;
  localparam int AW    = 4;

  localparam logic [WIDTH-1:0] V_A5   = {32{8'hA5}};
  localparam logic [WIDTH-1:0] V_0    = {32{8'h11}};
  localparam logic [WIDTH-1:0] V_1    = {32{8'h22}};
  localparam logic [WIDTH-1:0] V_10   = {32{8'h55}};
  localparam logic [WIDTH-1:0] V_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] V_ALL1 = {WIDTH{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             reqA, reqB, weA, weB;
  logic [AW-1:0]    addrA, addrB;
  logic [WIDTH-1:0] dinA, dinB;
  logic             gntA, gntB, rvalidA, rvalidB, errA, errB;
  logic [WIDTH-1:0] doutA, doutB;

  int n_checks = 0;
  int n_fails  = 0;

  ram_arb_256x11 #(.WIDTH(WIDTH), .DEPTH(11), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
    .gntA(gntA), .gntB(gntB), .doutA(doutA), .doutB(doutB),
    .rvalidA(rvalidA), .rvalidB(rvalidB), .errA(errA), .errB(errB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] din);
    reqA = req; weA = we; addrA = addr; dinA = din;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] din);
    reqB = req; weB = we; addrB = addr; dinB = din;
  endtask

  task automatic check_gnt(input string tag, input logic exp_a, input logic exp_b);
    #1;
    check({tag, "_gntA"}, {255'b0, gntA}, {255'b0, exp_a});
    check({tag, "_gntB"}, {255'b0, gntB}, {255'b0, exp_b});
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);

    // Reset state; requests made while reset is asserted are never granted.
    @(negedge clk);
    check("rst_rvalidA", {255'b0, rvalidA}, '0);
    check("rst_rvalidB", {255'b0, rvalidB}, '0);
    check("rst_doutA", doutA, '0);
    check("rst_doutB", doutB, '0);
    check("rst_errA", {255'b0, errA}, '0);
    check("rst_errB", {255'b0, errB}, '0);
    drive_a(1'b1, 1'b0, 4'd0, '0);
    drive_b(1'b1, 1'b0, 4'd1, '0);
    check_gnt("rst_req", 1'b0, 1'b0);
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back: A writes addr 3, then reads it on the next cycle.
    drive_a(1'b1, 1'b1, 4'd3, V_A5);
    check_gnt("wr3", 1'b1, 1'b0);
    @(negedge clk);
    drive_a(1'b1, 1'b0, 4'd3, '0);
    check_gnt("rd3", 1'b1, 1'b0);
    @(negedge clk);
    check("rd3_rvalidA", {255'b0, rvalidA}, 256'd1);
    check("rd3_doutA", doutA, V_A5);

    // Preload addr 0, 1 and 10 with back-to-back single-requester writes.
    drive_a(1'b1, 1'b1, 4'd0, V_0);
    check_gnt("wr0", 1'b1, 1'b0);
    @(negedge clk);
    check("wr0_rvalidA", {255'b0, rvalidA}, '0);
    drive_a(1'b1, 1'b1, 4'd1, V_1);
    check_gnt("wr1", 1'b1, 1'b0);
    @(negedge clk);
    drive_a(1'b1, 1'b1, 4'd10, V_10);
    check_gnt("wr10", 1'b1, 1'b0);
    @(negedge clk);
    drive_a(1'b0, 1'b0, '0, '0);

    // Second reset: clears doutA and restores the "B last" pointer.
    rst = 1'b1;
    #1;
    check("rst2_doutA", doutA, '0);
    @(negedge clk);
    rst = 1'b0;

    // Contention after reset: grants alternate A,B,A,B.
    drive_a(1'b1, 1'b0, 4'd0, '0);
    drive_b(1'b1, 1'b0, 4'd1, '0);
    check_gnt("cont0", 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("cont%0d_rvalidA", i), {255'b0, rvalidA}, {255'b0, i[0] == 1'b1});
      check($sformatf("cont%0d_rvalidB", i), {255'b0, rvalidB}, {255'b0, i[0] == 1'b0});
      if (i[0]) check($sformatf("cont%0d_doutA", i), doutA, V_0);
      else      check($sformatf("cont%0d_doutB", i), doutB, V_1);
      check_gnt($sformatf("cont%0d", i), i[0] == 1'b0, i[0] == 1'b1);
    end
    @(negedge clk);
    check("cont4_rvalidA", {255'b0, rvalidA}, '0);
    check("cont4_rvalidB", {255'b0, rvalidB}, 256'd1);
    check("cont4_doutB", doutB, V_1);

    // Cross-port access to addr 10: A reads old data, then B's write commits.
    drive_a(1'b1, 1'b0, 4'd10, '0);
    drive_b(1'b1, 1'b1, 4'd10, V_ONE);
    check_gnt("x10_a", 1'b1, 1'b0);
    @(negedge clk);
    check("x10_rvalidA", {255'b0, rvalidA}, 256'd1);
    check("x10_old_doutA", doutA, V_10);
    drive_a(1'b0, 1'b0, '0, '0);
    check_gnt("x10_b", 1'b0, 1'b1);
    @(negedge clk);
    check("x10_rvalidB", {255'b0, rvalidB}, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    drive_a(1'b1, 1'b0, 4'd10, '0);
    check_gnt("x10_rd", 1'b1, 1'b0);
    @(negedge clk);
    check("x10_rd_rvalidA", {255'b0, rvalidA}, 256'd1);
    check("x10_new_doutA", doutA, V_ONE);

    // Out of range: the write to addr 12 is dropped, and the read returns 0 and sets errA.
    drive_a(1'b1, 1'b1, 4'd12, V_ALL1);
    check_gnt("oor_wr", 1'b1, 1'b0);
    @(negedge clk);
    check("oor_wr_errA", {255'b0, errA}, 256'd1);
    check("oor_wr_errB", {255'b0, errB}, '0);
    check("oor_wr_rvalidA", {255'b0, rvalidA}, '0);
    drive_a(1'b1, 1'b0, 4'd12, '0);
    @(negedge clk);
    check("oor_rd_rvalidA", {255'b0, rvalidA}, 256'd1);
    check("oor_rd_doutA", doutA, '0);
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b1, 1'b0, 4'd1, '0);
    @(negedge clk);
    check("oor_mem1_doutB", doutB, V_1);
    drive_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("oor_sticky_errA", {255'b0, errA}, 256'd1);
    check("oor_sticky_errB", {255'b0, errB}, '0);

    // Reset during the read latency cycle suppresses rvalid and clears dout/err.
    drive_a(1'b1, 1'b0, 4'd3, '0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive_a(1'b0, 1'b0, '0, '0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rvalidA", {255'b0, rvalidA}, '0);
    check("midrst_doutA", doutA, '0);
    check("midrst_errA", {255'b0, errA}, '0);
    drive_a(1'b1, 1'b0, 4'd3, '0);
    check_gnt("midrst_rd", 1'b1, 1'b0);
    @(negedge clk);
    check("midrst_rd_rvalidA", {255'b0, rvalidA}, 256'd1);
    check("midrst_rd_doutA", doutA, V_A5);
    drive_a(1'b0, 1'b0, '0, '0);

    // Idle for 5 cycles: no grants and no rvalid.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_gnt($sformatf("idle%0d", i), 1'b0, 1'b0);
      check($sformatf("idle%0d_rvalidA", i), {255'b0, rvalidA}, '0);
      check($sformatf("idle%0d_rvalidB", i), {255'b0, rvalidB}, '0);
    end

    // The pointer still records "A last" after the idle cycles, so B wins a tie.
    drive_a(1'b1, 1'b0, 4'd0, '0);
    drive_b(1'b1, 1'b0, 4'd1, '0);
    check_gnt("idle_ptr", 1'b0, 1'b1);
    drive_a(1'b0, 1'b0, '0, '0);

    // B alone streams reads for 8 cycles at full throughput.
    for (int i = 0; i < 8; i++) begin
      check_gnt($sformatf("bstream%0d", i), 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("bstream%0d_rvalidB", i), {255'b0, rvalidB}, 256'd1);
      check($sformatf("bstream%0d_doutB", i), doutB, V_1);
    end
    drive_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
